// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, the bubble encoding and the fetch state type.
// Decode uses the same NOP_IR so both stages agree on what a bubble is.
package pipeline_pkg;

  localparam int PC_WIDTH = 16;
  localparam int IR_WIDTH = 32;

  localparam logic [7:0]          OP_NOP = 8'hFF;
  localparam logic [IR_WIDTH-1:0] NOP_IR = {OP_NOP, 24'h000000};

  typedef logic [PC_WIDTH-1:0] pc_t;
  typedef logic [IR_WIDTH-1:0] ir_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BR_WAIT
  } fetch_state_t;

  // PC arithmetic wraps silently at 2^PC_WIDTH.
  function automatic pc_t pc_advance(input pc_t pc, input pc_t step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: IMEM read port, Decode-facing outputs, stalls and redirect.
// master = fetch unit, slave = its environment (Decode, writeback, IMEM).
interface fetch_unit_if;
  import pipeline_pkg::*;

  logic I_LOCK;
  ir_t  I_IMemData;
  logic I_DepStallSignal;
  logic I_GPUStallSignal;
  logic I_BranchStallSignal;
  pc_t  I_WriteBackPC;
  logic I_WriteBackPCEn;

  pc_t  O_IMemAddr;
  logic O_IMemRdEn;
  logic O_LOCK;
  pc_t  O_PC;
  ir_t  O_IR;
  logic O_FE_Valid;

  modport master (
    input  I_LOCK, I_IMemData, I_DepStallSignal, I_GPUStallSignal,
           I_BranchStallSignal, I_WriteBackPC, I_WriteBackPCEn,
    output O_IMemAddr, O_IMemRdEn, O_LOCK, O_PC, O_IR, O_FE_Valid
  );

  modport slave (
    output I_LOCK, I_IMemData, I_DepStallSignal, I_GPUStallSignal,
           I_BranchStallSignal, I_WriteBackPC, I_WriteBackPCEn,
    input  O_IMemAddr, O_IMemRdEn, O_LOCK, O_PC, O_IR, O_FE_Valid
  );

endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC and a 1-cycle-latency IMEM read port, feeds Decode
// one instruction per cycle, and handles stalls, branch bubbles and writeback redirects.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter pc_t RESET_PC = '0,
  parameter pc_t PC_STEP  = 16'd4
) (
  input logic          I_CLOCK,
  input logic          I_RESET,
  fetch_unit_if.master fe
);

  fetch_state_t state;
  pc_t          fetch_pc;
  pc_t          pend_pc;
  logic         pend_valid;

  pc_t  out_pc;
  ir_t  out_ir;
  logic out_valid;
  logic out_lock;

  logic hold;
  pc_t  imem_addr;
  logic imem_rd_en;

  // A held cycle re-reads the pending address so the same word is presented again next cycle.
  always_comb begin
    hold       = fe.I_DepStallSignal | fe.I_GPUStallSignal;
    imem_addr  = fetch_pc;
    imem_rd_en = 1'b0;
    if (!I_RESET && fe.I_LOCK) begin
      case (state)
        IDLE: imem_rd_en = 1'b1;
        RUN: begin
          if (hold) begin
            imem_addr  = pend_pc;
            imem_rd_en = 1'b1;
          end else if (!fe.I_BranchStallSignal) begin
            imem_rd_en = 1'b1;
          end
        end
        BR_WAIT: begin
          if (fe.I_WriteBackPCEn) begin
            imem_addr  = fe.I_WriteBackPC;
            imem_rd_en = 1'b1;
          end
        end
        default: imem_rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      pend_pc    <= RESET_PC;
      pend_valid <= 1'b0;
      out_pc     <= '0;
      out_ir     <= NOP_IR;
      out_valid  <= 1'b0;
      out_lock   <= 1'b0;
    end else begin
      out_lock <= fe.I_LOCK;
      if (!fe.I_LOCK) begin
        // An unconsumed pending word is refetched once lock returns.
        out_ir     <= NOP_IR;
        out_valid  <= 1'b0;
        pend_valid <= 1'b0;
        state      <= IDLE;
        if (pend_valid) fetch_pc <= pend_pc;
      end else begin
        case (state)
          IDLE: begin
            out_ir     <= NOP_IR;
            out_valid  <= 1'b0;
            pend_pc    <= fetch_pc;
            pend_valid <= 1'b1;
            fetch_pc   <= pc_advance(fetch_pc, PC_STEP);
            state      <= RUN;
          end
          RUN: begin
            if (hold) begin
              state <= RUN;
            end else if (fe.I_BranchStallSignal) begin
              out_ir     <= NOP_IR;
              out_valid  <= 1'b0;
              pend_valid <= 1'b0;
              state      <= BR_WAIT;
            end else begin
              out_ir    <= fe.I_IMemData;
              out_pc    <= pend_pc;
              out_valid <= pend_valid;
              pend_pc   <= fetch_pc;
              fetch_pc  <= pc_advance(fetch_pc, PC_STEP);
            end
          end
          BR_WAIT: begin
            out_ir    <= NOP_IR;
            out_valid <= 1'b0;
            if (fe.I_WriteBackPCEn) begin
              pend_pc    <= fe.I_WriteBackPC;
              pend_valid <= 1'b1;
              fetch_pc   <= pc_advance(fe.I_WriteBackPC, PC_STEP);
              state      <= RUN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign fe.O_IMemAddr = imem_addr;
  assign fe.O_IMemRdEn = imem_rd_en;
  assign fe.O_LOCK     = out_lock;
  assign fe.O_PC       = out_pc;
  assign fe.O_IR       = out_ir;
  assign fe.O_FE_Valid = out_valid;

endmodule
